// File: rtl/ob_host.sv
// Host-side shim for the order-book core: registers upstream commands onto the
// book's ingress, buffers book responses for a downstream consumer, and keeps
// issue/response statistics plus a response watchdog.

package ob_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_ADD    = 2'd1,
    OP_CANCEL = 2'd2,
    OP_MODIFY = 2'd3
  } op_e;

  typedef struct packed {
    op_e         op;
    logic        side;
    logic [15:0] id;
    logic [15:0] price;
    logic [15:0] qty;
  } cmd_t;

  typedef struct packed {
    logic [1:0]  status;
    logic [15:0] id;
    logic [15:0] qty;
  } rsp_t;

endpackage

module ob_host
  import ob_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024,
  parameter int RSP_N   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  cmd_t             in_cmd,
  output logic             in_rdy,
  output logic             cmd_vld_r,
  output cmd_t             cmd_r,
  input  logic             cmd_full_r,
  input  logic             rsp_vld,
  input  rsp_t             rsp,
  output logic             rsp_accept,
  output logic             out_vld,
  output rsp_t             out_rsp,
  input  logic             out_accept,
  input  logic             halt,
  output logic             idle_r,
  output logic [CNT_W-1:0] cmd_cnt_r,
  output logic [CNT_W-1:0] rsp_cnt_r,
  output logic             err_timeout_r
);

  localparam int PTR_W = (RSP_N > 1) ? $clog2(RSP_N) : 1;
  localparam int OCC_W = $clog2(RSP_N + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [0:0] WD_OFF   = 1'b0;
  localparam logic [0:0] WD_ARMED = 1'b1;

  // Response buffer storage and bookkeeping
  rsp_t             mem [RSP_N];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_nxt;

  // Watchdog state
  logic [0:0]       wd_state;
  logic [0:0]       wd_state_nxt;
  logic [WD_W-1:0]  wd_cnt;
  logic [WD_W-1:0]  wd_cnt_nxt;
  logic             wd_fire;

  logic             issue;
  logic             push;
  logic             pop;
  logic             idle_nxt;

  // Handshakes are gated by rst so nothing transfers during the reset cycle.
  assign in_rdy     = ~rst & ~cmd_full_r & ~halt;
  assign issue      = in_vld & in_rdy;
  assign rsp_accept = ~rst & (occ < OCC_W'(RSP_N));
  assign push       = rsp_vld & rsp_accept;
  assign out_vld    = (occ != '0);
  assign pop        = out_vld & out_accept;
  assign out_rsp    = mem[rd_ptr];

  assign occ_nxt = occ + OCC_W'(push) - OCC_W'(pop);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wd_state_nxt = wd_state;
    wd_cnt_nxt   = wd_cnt;
    wd_fire      = 1'b0;
    if (issue) begin
      // A new issue always reloads, even if a response lands this same cycle.
      wd_state_nxt = WD_ARMED;
      wd_cnt_nxt   = WD_W'(TIMEOUT);
    end else if (wd_state == WD_ARMED) begin
      if (push) begin
        wd_state_nxt = WD_OFF;
      end else if (wd_cnt == WD_W'(1)) begin
        wd_state_nxt = WD_OFF;
        wd_cnt_nxt   = '0;
        wd_fire      = 1'b1;
      end else begin
        wd_cnt_nxt = wd_cnt - WD_W'(1);
      end
    end
  end

  assign idle_nxt = ~issue & (occ_nxt == '0) & (wd_state_nxt == WD_OFF);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_vld_r     <= 1'b0;
      cmd_r         <= '0;
      cmd_cnt_r     <= '0;
      rsp_cnt_r     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      wd_state      <= WD_OFF;
      wd_cnt        <= '0;
      err_timeout_r <= 1'b0;
      idle_r        <= 1'b1;
    end else begin
      cmd_vld_r <= issue;
      if (issue) begin
        cmd_r     <= in_cmd;
        cmd_cnt_r <= cmd_cnt_r + CNT_W'(1);
      end
      if (push) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        rsp_cnt_r <= rsp_cnt_r + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      occ      <= occ_nxt;
      wd_state <= wd_state_nxt;
      wd_cnt   <= wd_cnt_nxt;
      if (wd_fire) begin
        err_timeout_r <= 1'b1;
      end
      idle_r <= idle_nxt;
    end
  end

  // NOTE: the buffer payload is not reset; occupancy and pointers alone decide
  // what is valid, so clearing the entries would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rsp;
    end
  end

endmodule

// File: tb/tb_ob_host.sv
// Directed bench for ob_host with CNT_W=4, TIMEOUT=8, RSP_N=2; all expected
// values are hand-computed constants.

module tb_ob_host;
  import ob_pkg::*;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int RSP_N   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_vld;
  cmd_t             in_cmd;
  logic             in_rdy;
  logic             cmd_vld_r;
  cmd_t             cmd_r;
  logic             cmd_full_r;
  logic             rsp_vld;
  rsp_t             rsp;
  logic             rsp_accept;
  logic             out_vld;
  rsp_t             out_rsp;
  logic             out_accept;
  logic             halt;
  logic             idle_r;
  logic [CNT_W-1:0] cmd_cnt_r;
  logic [CNT_W-1:0] rsp_cnt_r;
  logic             err_timeout_r;

  int n_checks = 0;
  int n_fail   = 0;

  ob_host #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .RSP_N(RSP_N)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_vld        (in_vld),
    .in_cmd        (in_cmd),
    .in_rdy        (in_rdy),
    .cmd_vld_r     (cmd_vld_r),
    .cmd_r         (cmd_r),
    .cmd_full_r    (cmd_full_r),
    .rsp_vld       (rsp_vld),
    .rsp           (rsp),
    .rsp_accept    (rsp_accept),
    .out_vld       (out_vld),
    .out_rsp       (out_rsp),
    .out_accept    (out_accept),
    .halt          (halt),
    .idle_r        (idle_r),
    .cmd_cnt_r     (cmd_cnt_r),
    .rsp_cnt_r     (rsp_cnt_r),
    .err_timeout_r (err_timeout_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_vld     = 1'b0;
    in_cmd     = '0;
    cmd_full_r = 1'b0;
    rsp_vld    = 1'b0;
    rsp        = '0;
    out_accept = 1'b0;
    halt       = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic cmd_t mk_cmd(input int n);
    cmd_t c;
    c.op    = OP_ADD;
    c.side  = n[0];
    c.id    = 16'(16'h100 + n);
    c.price = 16'(16'h2000 + 3 * n);
    c.qty   = 16'(16'h0010 + n);
    return c;
  endfunction

  function automatic rsp_t mk_rsp(input int n);
    rsp_t r;
    r.status = 2'(n);
    r.id     = 16'(16'hA00 + n);
    r.qty    = 16'(16'h0050 + n);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    cmd_t cmds[3];

    // Reset state and handshake gating during reset
    rst        = 1'b1;
    in_vld     = 1'b1;
    in_cmd     = mk_cmd(9);
    cmd_full_r = 1'b0;
    rsp_vld    = 1'b1;
    rsp        = mk_rsp(9);
    out_accept = 1'b0;
    halt       = 1'b0;
    step();
    check("rst_in_rdy", 64'(in_rdy), 64'd0);
    check("rst_rsp_accept", 64'(rsp_accept), 64'd0);
    do_reset();
    check("rst_cmd_vld", 64'(cmd_vld_r), 64'd0);
    check("rst_cmd_r", 64'(cmd_r), 64'd0);
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_cmd_cnt", 64'(cmd_cnt_r), 64'd0);
    check("rst_rsp_cnt", 64'(rsp_cnt_r), 64'd0);
    check("rst_err", 64'(err_timeout_r), 64'd0);
    check("rst_idle", 64'(idle_r), 64'd1);

    // Three back-to-back commands
    for (int i = 0; i < 3; i++) cmds[i] = mk_cmd(i + 1);
    in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_cmd = cmds[i];
      #1;
      check("b2b_in_rdy", 64'(in_rdy), 64'd1);
      step();
      check("b2b_cmd_vld", 64'(cmd_vld_r), 64'd1);
      check("b2b_cmd_r", 64'(cmd_r), 64'(cmds[i]));
      check("b2b_idle", 64'(idle_r), 64'd0);
    end
    in_vld = 1'b0;
    check("b2b_cmd_cnt", 64'(cmd_cnt_r), 64'd3);
    step();
    check("b2b_vld_drop", 64'(cmd_vld_r), 64'd0);
    check("b2b_cmd_hold", 64'(cmd_r), 64'(cmds[2]));

    // Back-pressure from the book, then halt
    do_reset();
    in_vld     = 1'b1;
    in_cmd     = mk_cmd(4);
    cmd_full_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("full_in_rdy", 64'(in_rdy), 64'd0);
      step();
      check("full_cmd_vld", 64'(cmd_vld_r), 64'd0);
    end
    cmd_full_r = 1'b0;
    #1;
    check("full_release_rdy", 64'(in_rdy), 64'd1);
    step();
    check("full_issue_vld", 64'(cmd_vld_r), 64'd1);
    check("full_issue_cmd", 64'(cmd_r), 64'(mk_cmd(4)));
    in_cmd = mk_cmd(5);
    halt   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("halt_in_rdy", 64'(in_rdy), 64'd0);
      step();
      check("halt_cmd_vld", 64'(cmd_vld_r), 64'd0);
    end
    halt = 1'b0;
    #1;
    check("halt_release_rdy", 64'(in_rdy), 64'd1);
    step();
    in_vld = 1'b0;
    check("halt_issue_vld", 64'(cmd_vld_r), 64'd1);
    check("halt_issue_cmd", 64'(cmd_r), 64'(mk_cmd(5)));
    check("halt_cmd_cnt", 64'(cmd_cnt_r), 64'd2);

    // Response buffer fill, stall, pop, ordering
    do_reset();
    rsp_vld = 1'b1;
    rsp     = mk_rsp(1);
    #1;
    check("rb_acc1", 64'(rsp_accept), 64'd1);
    step();
    check("rb_vld1", 64'(out_vld), 64'd1);
    check("rb_head1", 64'(out_rsp), 64'(mk_rsp(1)));
    rsp = mk_rsp(2);
    #1;
    check("rb_acc2", 64'(rsp_accept), 64'd1);
    step();
    check("rb_head_still1", 64'(out_rsp), 64'(mk_rsp(1)));
    check("rb_cnt2", 64'(rsp_cnt_r), 64'd2);
    rsp = mk_rsp(3);
    #1;
    check("rb_full_acc", 64'(rsp_accept), 64'd0);
    step();
    check("rb_full_cnt", 64'(rsp_cnt_r), 64'd2);
    out_accept = 1'b1;
    #1;
    check("rb_full_pop_acc", 64'(rsp_accept), 64'd0);
    step();
    out_accept = 1'b0;
    check("rb_head2", 64'(out_rsp), 64'(mk_rsp(2)));
    #1;
    check("rb_acc3", 64'(rsp_accept), 64'd1);
    step();
    rsp_vld = 1'b0;
    check("rb_cnt3", 64'(rsp_cnt_r), 64'd3);
    check("rb_head2_hold", 64'(out_rsp), 64'(mk_rsp(2)));
    out_accept = 1'b1;
    step();
    check("rb_head3", 64'(out_rsp), 64'(mk_rsp(3)));
    check("rb_vld3", 64'(out_vld), 64'd1);
    step();
    out_accept = 1'b0;
    check("rb_empty", 64'(out_vld), 64'd0);
    check("rb_idle", 64'(idle_r), 64'd1);

    // Watchdog expiry: error exactly TIMEOUT cycles after issue
    do_reset();
    in_vld = 1'b1;
    in_cmd = mk_cmd(6);
    step();
    in_vld = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
      check("wd_no_err_yet", 64'(err_timeout_r), 64'd0);
    end
    step();
    check("wd_err_set", 64'(err_timeout_r), 64'd1);
    check("wd_err_idle", 64'(idle_r), 64'd1);
    for (int i = 0; i < 4; i++) step();
    check("wd_err_sticky", 64'(err_timeout_r), 64'd1);

    // Response on cycle 7 satisfies the watchdog
    do_reset();
    in_vld = 1'b1;
    in_cmd = mk_cmd(7);
    step();
    in_vld = 1'b0;
    for (int i = 1; i < 7; i++) step();
    rsp_vld = 1'b1;
    rsp     = mk_rsp(7);
    step();
    rsp_vld = 1'b0;
    check("wd7_busy_idle", 64'(idle_r), 64'd0);
    for (int i = 0; i < 6; i++) step();
    check("wd7_no_err", 64'(err_timeout_r), 64'd0);
    out_accept = 1'b1;
    step();
    out_accept = 1'b0;
    check("wd7_idle", 64'(idle_r), 64'd1);
    check("wd7_drained", 64'(out_vld), 64'd0);

    // Same-cycle response and issue re-arms with a full reload
    do_reset();
    in_vld = 1'b1;
    in_cmd = mk_cmd(8);
    step();
    in_vld = 1'b0;
    for (int i = 1; i < 5; i++) step();
    in_vld  = 1'b1;
    in_cmd  = mk_cmd(9);
    rsp_vld = 1'b1;
    rsp     = mk_rsp(8);
    step();
    in_vld  = 1'b0;
    rsp_vld = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
      check("rearm_no_err", 64'(err_timeout_r), 64'd0);
    end
    step();
    check("rearm_err", 64'(err_timeout_r), 64'd1);

    // Counter wrap, then reset with a full buffer and a live command
    do_reset();
    in_vld = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_cmd  = mk_cmd(20 + i);
      rsp_vld = (i >= 15);
      rsp     = mk_rsp(20 + i);
      step();
    end
    in_vld  = 1'b0;
    rsp_vld = 1'b0;
    check("wrap_cmd_cnt", 64'(cmd_cnt_r), 64'd1);
    check("wrap_rsp_cnt", 64'(rsp_cnt_r), 64'd2);
    check("pre_rst_cmd_vld", 64'(cmd_vld_r), 64'd1);
    check("pre_rst_out_vld", 64'(out_vld), 64'd1);
    rst        = 1'b1;
    in_vld     = 1'b1;
    rsp_vld    = 1'b1;
    out_accept = 1'b0;
    #1;
    check("midrst_in_rdy", 64'(in_rdy), 64'd0);
    check("midrst_rsp_accept", 64'(rsp_accept), 64'd0);
    step();
    check("midrst_out_vld", 64'(out_vld), 64'd0);
    check("midrst_cmd_vld", 64'(cmd_vld_r), 64'd0);
    check("midrst_cmd_cnt", 64'(cmd_cnt_r), 64'd0);
    check("midrst_rsp_cnt", 64'(rsp_cnt_r), 64'd0);
    check("midrst_idle", 64'(idle_r), 64'd1);
    rst     = 1'b0;
    in_vld  = 1'b0;
    rsp_vld = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ob_host.md
Name: ob_host

Overview:
- Host-side counterpart of the order-book core.
- Takes commands from an upstream source and drives them onto the book's command interface (cmd_vld_r / cmd_r, back-pressured by cmd_full_r).
- Consumes the book's response interface (rsp_vld / rsp, acknowledged by rsp_accept) into a small buffer, which is presented to a downstream consumer.
- Also provides issue/response statistics, a drain control, and a response watchdog for system-level error detection.

Parameters:
- CNT_W, 32, width of the issued-command and accepted-response counters (wrap modulo 2^CNT_W).
- TIMEOUT, 1024, cycles allowed between a command issue and the next accepted response before a watchdog error (must be >= 1).
- RSP_N, 2, response buffer depth (power of two, >= 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  upstream command valid.
- in_cmd  in  $bits(ob_pkg::cmd_t)  upstream command.
- in_rdy  out  1  upstream ready; command transfers when in_vld & in_rdy.
- cmd_vld_r  out  1  registered command valid to the book.
- cmd_r  out  $bits(ob_pkg::cmd_t)  registered command to the book.
- cmd_full_r  in  1  book ingress full (registered at source).
- rsp_vld  in  1  book response valid.
- rsp  in  $bits(ob_pkg::rsp_t)  book response.
- rsp_accept  out  1  response acknowledge; response transfers when rsp_vld & rsp_accept.
- out_vld  out  1  downstream response valid.
- out_rsp  out  $bits(ob_pkg::rsp_t)  downstream response (head of buffer).
- out_accept  in  1  downstream pop.
- halt  in  1  stop issuing new commands (drain).
- idle_r  out  1  nothing issued in flight, buffer empty, no watchdog pending.
- cmd_cnt_r  out  CNT_W  commands issued.
- rsp_cnt_r  out  CNT_W  responses accepted from the book.
- err_timeout_r  out  1  sticky watchdog error.

Behaviour:
- Reset values: cmd_vld_r=0, cmd_r=0, buffer empty (out_vld=0), counters=0, err_timeout_r=0, idle_r=1, watchdog disarmed.
- Issue path:
  - in_rdy = ~cmd_full_r & ~halt (combinational).
  - On transfer: next cycle cmd_vld_r=1 and cmd_r=in_cmd; cmd_cnt_r increments.
  - Otherwise cmd_vld_r=0 next cycle; cmd_r holds its last value.
  - Issue latency is exactly one cycle; cmd_vld_r is a single-cycle pulse per command.
  - Back-to-back issue is allowed every cycle while in_rdy=1.
- Halt: affects only the issue path. Responses continue to be accepted and delivered. Deasserting halt resumes issue the same cycle.
- Response path:
  - rsp_accept = (buffer occupancy < RSP_N) (combinational); there is no dependency on out_accept.
  - On transfer: rsp is written at the tail; rsp_cnt_r increments.
  - out_vld = occupancy != 0; out_rsp = head entry.
  - Pop on out_vld & out_accept.
  - Simultaneous push and pop when full: push is not accepted (rsp_accept=0); the pop proceeds.
  - Simultaneous push and pop when not full: occupancy is unchanged.
  - Pointers wrap modulo RSP_N; order is preserved.
- Watchdog:
  - A command issue arms the watchdog and loads its counter with TIMEOUT.
  - Each cycle without an accepted response while armed decrements the counter.
  - An accepted response disarms it, unless an issue occurs the same cycle, in which case it re-arms and reloads (issue wins).
  - Counter reaching 0 while armed sets err_timeout_r; the watchdog disarms.
  - err_timeout_r clears only on rst.
  - The watchdog does not pair commands to responses; one response satisfies all outstanding issues.
- idle_r: registered; = ~cmd_vld_r & (occupancy==0) & ~armed, computed from next-state values.
- Counters: wrap silently from 2^CNT_W-1 to 0.
- Reset mid-operation:
  - The in-flight cmd_vld_r is dropped in the reset cycle.
  - Buffered responses are discarded.
  - No handshake outputs assert during rst (in_rdy=0, rsp_accept=0).

Test Plan:
- Reset then 3 commands on consecutive cycles, cmd_full_r=0 -> cmd_vld_r high for 3 consecutive cycles, each starting one cycle after its transfer; cmd_r matches in order; cmd_cnt_r=3.
- cmd_full_r=1 for 5 cycles with in_vld=1 -> in_rdy=0 and cmd_vld_r=0 throughout; the command issues one cycle after cmd_full_r falls. Repeat with halt=1 -> same stall; on release, the command issues next cycle.
- RSP_N=2, out_accept=0, 3 responses offered back-to-back -> first 2 accepted; rsp_accept=0 on the 3rd. Assert out_accept for 1 cycle -> 3rd accepted next cycle; out_rsp order 1,2,3; rsp_cnt_r=3.
- TIMEOUT=8, issue 1 command, no responses -> err_timeout_r=1 exactly 8 cycles after issue and stays set. Response at cycle 7 instead -> err_timeout_r stays 0 and idle_r returns to 1 once the buffer drains.
- Response accepted and new command issued in the same cycle -> watchdog re-armed with a full TIMEOUT reload.
- CNT_W=4, issue 17 commands -> cmd_cnt_r=1. Assert rst with 2 buffered responses and cmd_vld_r high -> next cycle out_vld=0, cmd_vld_r=0, counters=0, idle_r=1.
